updown_chain: RTL and testbench

UPDOWN_CHAIN -- requirements
Module: updown_chain

---
 rtl/counter_pkg.sv | 19 +
 rtl/counter_digit.sv | 42 ++++
 rtl/updown_chain.sv | 99 +++++++++
 tb/tb_updown_chain.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the cascaded up/down counter.
// Latency: none (package only).
// Backpressure: none (package only).
package counter_pkg;

  // MODE encodings: wrap around at the bounds, or saturate and hold there.
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Ceiling log2, used to size one digit; returns at least 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/counter_digit.sv
// One mod-MOD digit with up/down step, parallel load and bound flags.
// Latency: value updates one CLK after a step or load request.
// Backpressure: none; step/load are accepted on every edge.
module counter_digit #(
  parameter int MOD = 10,
  parameter int W   = 4
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         up_en,
  input  logic         dn_en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         at_max,
  output logic         at_zero
);

  localparam logic [W-1:0] MAXV = W'(MOD - 1);
  localparam logic [W:0]   MODV = (W + 1)'(MOD);

  logic [W-1:0] load_clamped;

  // Out-of-range load fields clamp to the largest legal digit value.
  assign load_clamped = ({1'b0, load_val} >= MODV) ? MAXV : load_val;
  assign at_max       = (value == MAXV);
  assign at_zero      = (value == '0);

  // Digit register: load wins, otherwise step up or down with wrap at the digit bounds.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      value <= '0;
    end else if (load) begin
      value <= load_clamped;
    end else if (up_en) begin
      value <= at_max ? '0 : value + W'(1);
    end else if (dn_en) begin
      value <= at_zero ? MAXV : value - W'(1);
    end
  end

endmodule

// File: rtl/updown_chain.sv
// Cascade of DIGITS mod-MOD digits counting up/down with wrap or saturate bounds.
// Latency: Q, CARRY and BORROW update one CLK after the sampled request; ZERO follows Q.
// Backpressure: none; a request is acted on every cycle it is sampled.
module updown_chain
  import counter_pkg::*;
#(
  parameter  int MOD    = 10,
  parameter  int DIGITS = 4,
  localparam int W      = clog2(MOD)
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                EN,
  input  logic                INC,
  input  logic                DEC,
  input  logic                LOAD,
  input  logic [DIGITS*W-1:0] D,
  input  logic                MODE,
  output logic [DIGITS*W-1:0] Q,
  output logic                CARRY,
  output logic                BORROW,
  output logic                ZERO
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] up_en;
  logic [DIGITS-1:0] dn_en;
  logic              step_up;
  logic              step_dn;
  logic              all_max;
  logic              all_zero;
  logic              ovf;
  logic              udf;
  logic              sat;

  // Decode the request: load has priority, simultaneous INC and DEC cancel out.
  always_comb begin
    step_up  = 1'b0;
    step_dn  = 1'b0;
    if (!LOAD && EN && (INC != DEC)) begin
      step_up = INC;
      step_dn = DEC;
    end
    all_max  = &at_max;
    all_zero = &at_zero;
    sat      = (MODE == MODE_SAT);
    ovf      = step_up && all_max;
    udf      = step_dn && all_zero;
  end

  // Ripple: a digit steps only when every lower digit is at its bound; a saturating
  // overflow/underflow blocks the whole chain so Q holds.
  always_comb begin
    logic acc_up;
    logic acc_dn;
    up_en  = '0;
    dn_en  = '0;
    acc_up = step_up && !(ovf && sat);
    acc_dn = step_dn && !(udf && sat);
    for (int i = 0; i < DIGITS; i++) begin
      up_en[i] = acc_up;
      dn_en[i] = acc_dn;
      acc_up   = acc_up && at_max[i];
      acc_dn   = acc_dn && at_zero[i];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    counter_digit #(
      .MOD (MOD),
      .W   (W)
    ) u_digit (
      .CLK      (CLK),
      .CLR      (CLR),
      .up_en    (up_en[g]),
      .dn_en    (dn_en[g]),
      .load     (LOAD),
      .load_val (D[g*W +: W]),
      .value    (Q[g*W +: W]),
      .at_max   (at_max[g]),
      .at_zero  (at_zero[g])
    );
  end

  // Bound pulses: one cycle per overflow/underflow event, in both modes.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      CARRY  <= 1'b0;
      BORROW <= 1'b0;
    end else begin
      CARRY  <= ovf;
      BORROW <= udf;
    end
  end

  assign ZERO = all_zero;

endmodule

// File: tb/tb_updown_chain.sv
// Randomized and directed bench for updown_chain against an integer reference count.
// Latency: checks each output 1 time unit after the rising edge that produced it.
// Backpressure: none.
module tb_updown_chain;

  localparam int MOD    = 10;
  localparam int DIGITS = 4;
  localparam int W      = 4;
  localparam int DW     = DIGITS * W;
  localparam int MAXN   = MOD ** DIGITS - 1;

  logic          CLK = 1'b0;
  logic          CLR;
  logic          EN;
  logic          INC;
  logic          DEC;
  logic          LOAD;
  logic          MODE;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;
  logic          CARRY;
  logic          BORROW;
  logic          ZERO;

  int   checks   = 0;
  int   failures = 0;

  // Reference: the count as a plain integer, plus the expected pulses.
  int   m_n;
  logic m_c;
  logic m_b;

  updown_chain #(
    .MOD    (MOD),
    .DIGITS (DIGITS)
  ) dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .EN     (EN),
    .INC    (INC),
    .DEC    (DEC),
    .LOAD   (LOAD),
    .D      (D),
    .MODE   (MODE),
    .Q      (Q),
    .CARRY  (CARRY),
    .BORROW (BORROW),
    .ZERO   (ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] to_q(input int n);
    logic [DW-1:0] out;
    int            r;
    out = '0;
    r   = n;
    for (int i = 0; i < DIGITS; i++) begin
      out[i*W +: W] = W'(r % MOD);
      r = r / MOD;
    end
    return out;
  endfunction

  function automatic int from_d(input logic [DW-1:0] d);
    int n;
    int p;
    int f;
    n = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      f = int'(d[i*W +: W]);
      if (f >= MOD) f = MOD - 1;
      n = n + f * p;
      p = p * MOD;
    end
    return n;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".q"},      32'(Q),      32'(to_q(m_n)));
    check({tag, ".carry"},  32'(CARRY),  32'(m_c));
    check({tag, ".borrow"}, 32'(BORROW), 32'(m_b));
    check({tag, ".zero"},   32'(ZERO),   32'(m_n == 0));
  endtask

  // Drive one cycle of inputs, advance the reference, then compare after the edge.
  task automatic cyc(input logic ld, input logic [DW-1:0] dv, input logic en,
                     input logic inc, input logic dec, input logic md, input string tag);
    LOAD = ld;
    D    = dv;
    EN   = en;
    INC  = inc;
    DEC  = dec;
    MODE = md;
    @(posedge CLK);
    m_c = 1'b0;
    m_b = 1'b0;
    if (ld) begin
      m_n = from_d(dv);
    end else if (en && (inc != dec)) begin
      if (inc) begin
        if (m_n == MAXN) begin
          m_c = 1'b1;
          if (!md) m_n = 0;
        end else begin
          m_n = m_n + 1;
        end
      end else begin
        if (m_n == 0) begin
          m_b = 1'b1;
          if (!md) m_n = MAXN;
        end else begin
          m_n = m_n - 1;
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic          md;
    logic [31:0]   r;
    logic [DW-1:0] dv;
    int            k;

    CLR  = 1'b1;
    EN   = 1'b0;
    INC  = 1'b0;
    DEC  = 1'b0;
    LOAD = 1'b0;
    MODE = 1'b0;
    D    = '0;
    m_n  = 0;
    m_c  = 1'b0;
    m_b  = 1'b0;

    #2;
    check_all("reset");
    #10;
    CLR = 1'b0;

    // Wrap overflow 9999 -> 0000 with a single CARRY pulse.
    cyc(1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, "load9999");
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, "ovf_wrap");
    check("ovf_wrap.q_const", 32'(Q), 32'h0);
    check("ovf_wrap.carry_const", 32'(CARRY), 32'h1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, "after_ovf");

    // Saturating overflows back to back: one CARRY per event, Q holds.
    cyc(1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b1, "load9999s");
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, "ovf_sat1");
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, "ovf_sat2");
    check("ovf_sat2.carry_const", 32'(CARRY), 32'h1);

    // Underflow in both modes.
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "load0");
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "udf_wrap");
    check("udf_wrap.q_const", 32'(Q), 32'h9999);
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, "load0s");
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, "udf_sat");
    check("udf_sat.borrow_const", 32'(BORROW), 32'h1);

    // Multi-digit ripple without a bound pulse.
    cyc(1'b1, 16'h0199, 1'b0, 1'b0, 1'b0, 1'b0, "load0199");
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, "inc0199");
    check("inc0199.q_const", 32'(Q), 32'h0200);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "dec0200");

    // Both requests, or EN low, leave Q alone.
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, "incdec");
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, "en_low");
    check("hold.q_const", 32'(Q), 32'h0199);

    // Load clamping, and load overriding a would-be overflow.
    cyc(1'b1, 16'hF3C1, 1'b0, 1'b0, 1'b0, 1'b0, "clamp");
    check("clamp.q_const", 32'(Q), 32'h9391);
    cyc(1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, "load9999b");
    cyc(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, "load_vs_ovf");

    // Asynchronous clear in the middle of a CARRY pulse.
    cyc(1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, "load9999c");
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, "ovf_pre_clr");
    #3;
    CLR = 1'b1;
    #1;
    m_n = 0;
    m_c = 1'b0;
    m_b = 1'b0;
    check_all("clr_async");
    @(posedge CLK);
    #1;
    check_all("clr_held");
    #2;
    CLR = 1'b0;
    @(posedge CLK);
    #1;
    m_n = 1;
    check_all("clr_release");
    check("clr_release.q_const", 32'(Q), 32'h0001);

    // Random traffic, biased toward the bounds.
    md = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) md = ~md;
      k = $urandom_range(0, 3);
      r = $urandom;
      case (k)
        0:       dv = r[DW-1:0];
        1:       dv = 16'h9999;
        2:       dv = 16'h0000;
        default: dv = to_q($urandom_range(0, MAXN));
      endcase
      cyc(($urandom_range(0, 99) < 8), dv, ($urandom_range(0, 7) != 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), md, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
